de2_70_nios_ocimem_arbiter: RTL and testbench

Arbitrates the Nios II on-chip debug memory (OCI RAM, single port, 32-bit) between the JTAG debug host command path and the CPU-side Avalon debug slave. Grants one access at a time, sequences the RAM strobes, and routes read data back to the winning requester. Sits between the JTAG debug module's sysclk-domain command decode and the OCI RAM macro.

---
 rtl/de2_70_nios_ocimem_arbiter.sv | 132 +++++++++++++
 tb/tb_de2_70_nios_ocimem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/de2_70_nios_ocimem_arbiter.sv
// Single-port OCI RAM arbiter between the JTAG debug command path and the Avalon debug slave.
// Define DE2_70_OCIMEM_ARB_JTAG_PRIORITY_EN for fixed JTAG priority; default is round-robin.
module de2_70_nios_ocimem_arbiter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          j_req,
    input  logic          j_wr,
    input  logic [AW-1:0] j_addr,
    input  logic [31:0]   j_wdata,
    output logic          j_gnt,
    output logic          j_rvalid,
    output logic [31:0]   j_rdata,
    input  logic          av_read,
    input  logic          av_write,
    input  logic [AW-1:0] av_address,
    input  logic [31:0]   av_writedata,
    output logic          av_waitrequest,
    output logic          av_readdatavalid,
    output logic [31:0]   av_readdata,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [31:0]   ram_rdata,
    output logic          busy
);

    // state | meaning
    // IDLE  | no access in flight; arbitrate, deliver last read's valid pulse
    // ISSUE | RAM strobe for the granted access; grant/accept to owner
    // RDATA | RAM read data returning; capture into owner's rdata register
    typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

    localparam logic OWN_JTAG = 1'b0;
    localparam logic OWN_AV   = 1'b1;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;
    logic          op_wr, op_wr_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [31:0]   wdata_q, wdata_nxt;
    logic          av_req;
    logic          j_wins;

    assign av_req = av_read | av_write;

`ifdef DE2_70_OCIMEM_ARB_JTAG_PRIORITY_EN
    assign j_wins = j_req;
`else
    logic last_owner;

    // On a tie the side that did not win last time is served.
    assign j_wins = j_req && (!av_req || last_owner == OWN_AV);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= OWN_AV;
        end else if (state == IDLE && (j_req || av_req)) begin
            last_owner <= j_wins ? OWN_JTAG : OWN_AV;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        op_wr_nxt = op_wr;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        case (state)
            IDLE: begin
                if (j_req || av_req) begin
                    state_nxt = ISSUE;
                    if (j_wins) begin
                        owner_nxt = OWN_JTAG;
                        op_wr_nxt = j_wr;
                        addr_nxt  = j_addr;
                        wdata_nxt = j_wdata;
                    end else begin
                        // Write takes precedence when both Avalon strobes are high.
                        owner_nxt = OWN_AV;
                        op_wr_nxt = av_write;
                        addr_nxt  = av_address;
                        wdata_nxt = av_writedata;
                    end
                end
            end
            ISSUE:   state_nxt = op_wr ? IDLE : RDATA;
            RDATA:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            owner            <= OWN_JTAG;
            op_wr            <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            j_rvalid         <= 1'b0;
            j_rdata          <= '0;
            av_readdatavalid <= 1'b0;
            av_readdata      <= '0;
        end else begin
            state            <= state_nxt;
            owner            <= owner_nxt;
            op_wr            <= op_wr_nxt;
            addr_q           <= addr_nxt;
            wdata_q          <= wdata_nxt;
            j_rvalid         <= (state == RDATA) && (owner == OWN_JTAG);
            av_readdatavalid <= (state == RDATA) && (owner == OWN_AV);
            if (state == RDATA && owner == OWN_JTAG) begin
                j_rdata <= ram_rdata;
            end
            if (state == RDATA && owner == OWN_AV) begin
                av_readdata <= ram_rdata;
            end
        end
    end

    assign j_gnt          = (state == ISSUE) && (owner == OWN_JTAG);
    assign av_waitrequest = !((state == ISSUE) && (owner == OWN_AV));
    assign ram_we         = (state == ISSUE) && op_wr;
    assign ram_re         = (state == ISSUE) && !op_wr;
    assign ram_addr       = addr_q;
    assign ram_wdata      = wdata_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_de2_70_nios_ocimem_arbiter.sv
// Scoreboard bench for the OCI RAM arbiter: directed stimulus pushes expectations,
// a negedge monitor pops and compares grants, RAM writes and read data.
module tb_de2_70_nios_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        j_req, j_wr;
    logic [7:0]  j_addr;
    logic [31:0] j_wdata;
    logic        j_gnt, j_rvalid;
    logic [31:0] j_rdata;
    logic        av_read, av_write;
    logic [7:0]  av_address;
    logic [31:0] av_writedata;
    logic        av_waitrequest, av_readdatavalid;
    logic [31:0] av_readdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we, ram_re;
    logic [31:0] ram_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int          exp_gnt[$];
    logic [39:0] exp_wr[$];
    logic [31:0] exp_jd[$];
    logic [31:0] exp_avd[$];

    always #5 clk = ~clk;

    de2_70_nios_ocimem_arbiter #(.AW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .j_req(j_req), .j_wr(j_wr), .j_addr(j_addr), .j_wdata(j_wdata),
        .j_gnt(j_gnt), .j_rvalid(j_rvalid), .j_rdata(j_rdata),
        .av_read(av_read), .av_write(av_write), .av_address(av_address),
        .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
        .av_readdatavalid(av_readdatavalid), .av_readdata(av_readdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM model: locations never written return a fixed preload pattern.
    logic [31:0] mem [256];
    logic [255:0] written = '0;

    function automatic logic [31:0] preload(input logic [7:0] a);
        case (a)
            8'h03:   return 32'h1234_5678;
            8'h20:   return 32'hAAAA_0020;
            8'h21:   return 32'hBBBB_0021;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        if (ram_re) ram_rdata <= written[ram_addr] ? mem[ram_addr] : preload(ram_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (j_gnt && !av_waitrequest) fail("dual_grant", 32'd1, 32'd0);
                else if (j_gnt || !av_waitrequest) begin
                    if (exp_gnt.size() == 0) fail("unexpected_grant", {31'd0, !av_waitrequest}, 32'd2);
                    else check("grant_owner", {31'd0, !av_waitrequest}, 32'(exp_gnt.pop_front()));
                end
                if (ram_we && ram_re) fail("dual_strobe", 32'd1, 32'd0);
                if (ram_we) begin
                    if (exp_wr.size() == 0) fail("unexpected_write", {24'd0, ram_addr}, 32'd0);
                    else begin
                        e = exp_wr.pop_front();
                        check("ram_wr_addr", {24'd0, ram_addr}, {24'd0, e[39:32]});
                        check("ram_wr_data", ram_wdata, e[31:0]);
                    end
                end
                if (j_rvalid) begin
                    if (exp_jd.size() == 0) fail("unexpected_j_rvalid", j_rdata, 32'd0);
                    else check("j_rdata", j_rdata, exp_jd.pop_front());
                end
                if (av_readdatavalid) begin
                    if (exp_avd.size() == 0) fail("unexpected_av_rdv", av_readdata, 32'd0);
                    else check("av_readdata", av_readdata, exp_avd.pop_front());
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1.
    task automatic j_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input int lat, input int rv_lat);
        int n;
        exp_gnt.push_back(0);
        if (wr) exp_wr.push_back({a, d});
        else exp_jd.push_back(d);
        j_req = 1'b1; j_wr = wr; j_addr = a; j_wdata = wr ? d : 32'h0;
        n = 0;
        while (n < 50) begin
            @(negedge clk); n++;
            if (j_gnt) break;
        end
        if (!j_gnt) fail("j_gnt_timeout", 32'(n), 32'(lat));
        else if (lat > 0) check("j_gnt_latency", 32'(n), 32'(lat));
        @(posedge clk); #1;
        j_req = 1'b0;
        if (!wr && rv_lat > 0) begin
            n = 0;
            while (n < 20) begin
                @(negedge clk); n++;
                if (j_rvalid) break;
            end
            check("j_rvalid_latency", 32'(n), 32'(rv_lat));
            @(posedge clk); #1;
        end
    endtask

    task automatic av_op(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input int lat, input int rv_lat);
        int n;
        exp_gnt.push_back(1);
        if (wr) exp_wr.push_back({a, d});
        else exp_avd.push_back(d);
        av_read = rd; av_write = wr; av_address = a; av_writedata = wr ? d : 32'h0;
        n = 0;
        while (n < 50) begin
            @(negedge clk); n++;
            if (!av_waitrequest) break;
        end
        if (av_waitrequest) fail("av_wait_timeout", 32'(n), 32'(lat));
        else if (lat > 0) check("av_accept_latency", 32'(n), 32'(lat));
        @(posedge clk); #1;
        av_read = 1'b0; av_write = 1'b0;
        @(negedge clk);
        check("av_wait_one_cycle", {31'd0, av_waitrequest}, 32'd1);
        if (!wr && rv_lat > 0) begin
            n = 1;
            while (!av_readdatavalid && n < 20) begin
                @(negedge clk); n++;
            end
            check("av_rdv_latency", 32'(n), 32'(rv_lat));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int g, cyc;
        reset_n = 1'b0;
        j_req = 1'b0; j_wr = 1'b0; j_addr = '0; j_wdata = '0;
        av_read = 1'b0; av_write = 1'b0; av_address = '0; av_writedata = '0;

        repeat (2) @(negedge clk);
        check("rst_av_waitrequest", {31'd0, av_waitrequest}, 32'd1);
        check("rst_pulses", {28'd0, j_gnt, j_rvalid, av_readdatavalid, busy}, 32'd0);
        check("rst_ram_strobes", {30'd0, ram_we, ram_re}, 32'd0);
        check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
        check("rst_rdata", j_rdata | av_readdata | ram_wdata, 32'd0);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ram_strobes", {29'd0, ram_we, ram_re, busy}, 32'd0);
        end

        // Both sides hold read requests from reset.
        for (int i = 0; i < 8; i++) begin
`ifdef DE2_70_OCIMEM_ARB_JTAG_PRIORITY_EN
            exp_gnt.push_back(0);
            exp_jd.push_back(32'hAAAA_0020);
`else
            exp_gnt.push_back(i % 2);
            if (i % 2 == 0) exp_jd.push_back(32'hAAAA_0020);
            else exp_avd.push_back(32'hBBBB_0021);
`endif
        end
        @(posedge clk); #1;
        j_req = 1'b1; j_wr = 1'b0; j_addr = 8'h20;
        av_read = 1'b1; av_address = 8'h21;
        g = 0; cyc = 0;
        while (g < 8 && cyc < 300) begin
            @(negedge clk); cyc++;
            if (j_gnt || !av_waitrequest) g++;
        end
        if (g < 8) fail("concurrent_timeout", 32'(g), 32'd8);
        @(posedge clk); #1;
        j_req = 1'b0; av_read = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // JTAG write then immediate read back.
        j_op(1'b1, 8'h10, 32'h5A5A_A5A5, 2, 0);
        j_op(1'b0, 8'h10, 32'h5A5A_A5A5, 2, 2);

        // Avalon read of preloaded word.
        av_op(1'b1, 1'b0, 8'h03, 32'h1234_5678, 2, 2);

        // Avalon read+write together: write wins, no read data.
        av_op(1'b1, 1'b1, 8'h04, 32'hDEAD_BEEF, 2, 0);
        repeat (4) @(posedge clk);
        #1;
        av_op(1'b1, 1'b0, 8'h04, 32'hDEAD_BEEF, 2, 2);

        // Reset during RDATA of a JTAG read: access dropped, no valid pulse.
        exp_gnt.push_back(0);
        j_req = 1'b1; j_wr = 1'b0; j_addr = 8'h10;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk); cyc++;
            if (j_gnt) break;
        end
        if (!j_gnt) fail("abort_gnt_timeout", 32'(cyc), 32'd2);
        @(posedge clk); #1;
        j_req = 1'b0;
        check("abort_busy_in_rdata", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy_after_rst", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_rvalid", {30'd0, j_rvalid, busy}, 32'd0);
        end
        @(posedge clk); #1;
        j_op(1'b0, 8'h10, 32'h5A5A_A5A5, 2, 2);

        cyc = 0;
        while ((exp_gnt.size() + exp_wr.size() + exp_jd.size() + exp_avd.size()) != 0 && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        check("scoreboard_drained",
              32'(exp_gnt.size() + exp_wr.size() + exp_jd.size() + exp_avd.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
